// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit_if
// Purpose  : Request/result bundle between the issue logic and alu_exec_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_exec_unit_if #(
    parameter int WIDTH = 24
);
    logic             start;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (
        output start, alu_ctrl, a, b,
        input  busy, done, result, zero, overflow, illegal
    );

    modport slave (
        input  start, alu_ctrl, a, b,
        output busy, done, result, zero, overflow, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Registered execute stage: single-cycle ALU ops plus a 24-step
//            iterative shift-add multiplier behind a busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH = 24
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    alu_exec_unit_if.slave  bus
);
    localparam logic [3:0] C_AND   = 4'b0000;
    localparam logic [3:0] C_OR    = 4'b0001;
    localparam logic [3:0] C_ADD   = 4'b0010;
    localparam logic [3:0] C_SLT   = 4'b0011;
    localparam logic [3:0] C_ADDLS = 4'b0100;
    localparam logic [3:0] C_XOR   = 4'b0101;
    localparam logic [3:0] C_SLL   = 4'b0110;
    localparam logic [3:0] C_MUL   = 4'b0111;
    localparam logic [3:0] C_SUB   = 4'b1010;
    localparam logic [3:0] C_SUBBR = 4'b1100;
    localparam logic [4:0] C_LAST  = 5'(WIDTH - 1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [4:0]       r_cnt;
    logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_zero, r_ovf, r_ill, r_done;

    logic             w_accept, w_is_mul, w_is_sub, w_mul_last;
    logic [WIDTH-1:0] w_b_eff, w_sum, w_res, w_acc_nxt;
    logic             w_ovf, w_ill;

    assign w_accept   = bus.start && (r_state == S_IDLE);
    assign w_is_mul   = (bus.alu_ctrl == C_MUL);
    assign w_mul_last = (r_state == S_MUL) && (r_cnt == C_LAST);

    assign w_is_sub   = (bus.alu_ctrl == C_SUB) || (bus.alu_ctrl == C_SUBBR);
    assign w_b_eff    = w_is_sub ? (~bus.b + WIDTH'(1)) : bus.b;
    assign w_sum      = bus.a + w_b_eff;
    assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
            S_MUL:   if (w_mul_last)           w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        case (bus.alu_ctrl)
            C_AND: w_res = bus.a & bus.b;
            C_OR:  w_res = bus.a | bus.b;
            C_XOR: w_res = bus.a ^ bus.b;
            C_ADD, C_ADDLS, C_SUB, C_SUBBR: begin
                w_res = w_sum;
                w_ovf = (bus.a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            C_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            C_SLL: w_res = (int'(bus.b[4:0]) >= WIDTH) ? '0 : (bus.a << bus.b[4:0]);
            C_MUL: w_res = '0;
            default: w_ill = 1'b1;
        endcase
    end

    // Multiplier operands stay frozen while idle; only the accept edge loads them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_ill    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_ill  <= 1'b0;
            if (w_accept) begin
                if (w_is_mul) begin
                    r_mcand  <= bus.a;
                    r_mplier <= bus.b;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end else begin
                    r_result <= w_res;
                    r_zero   <= (w_res == '0);
                    r_ovf    <= w_ovf;
                    r_ill    <= w_ill;
                    r_done   <= 1'b1;
                end
            end else if (r_state == S_MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 5'd1;
                if (w_mul_last) begin
                    r_result <= w_acc_nxt;
                    r_zero   <= (w_acc_nxt == '0);
                    r_ovf    <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign bus.busy     = (r_state == S_MUL);
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.zero     = r_zero;
    assign bus.overflow = r_ovf;
    assign bus.illegal  = r_ill;
endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Self-checking bench: vector table plus multiply/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [3:0]  ctrl;
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] res;
        logic        z;
        logic        ov;
        logic        il;
    } vec_t;

    typedef struct {
        logic [23:0] res;
        logic        z;
        logic        ov;
        logic        il;
    } exp_t;

    vec_t vecs[16];
    exp_t sbq[$];

    alu_exec_unit_if #(.WIDTH(24)) bus ();

    alu_exec_unit #(.WIDTH(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] c, input logic [23:0] a, input logic [23:0] b,
                         input bit push, input logic [23:0] r, input logic z,
                         input logic ov, input logic il);
        exp_t e;
        bus.start    = 1'b1;
        bus.alu_ctrl = c;
        bus.a        = a;
        bus.b        = b;
        if (push) begin
            e.res = r; e.z = z; e.ov = ov; e.il = il;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("illegal_only_with_done", {31'd0, bus.illegal & ~bus.done}, 32'd0);
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_result",   {8'd0, bus.result},    {8'd0, e.res});
                    chk("sb_zero",     {31'd0, bus.zero},     {31'd0, e.z});
                    chk("sb_overflow", {31'd0, bus.overflow}, {31'd0, e.ov});
                    chk("sb_illegal",  {31'd0, bus.illegal},  {31'd0, e.il});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{4'b0010, 24'h7FFFFF, 24'h000001, 24'h800000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{4'b1100, 24'h000123, 24'h000123, 24'h000000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{4'b0011, 24'hFFFFFF, 24'h000001, 24'h000001, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4'b0110, 24'h000001, 24'd23,     24'h800000, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'b0110, 24'h000001, 24'd24,     24'h000000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{4'b0000, 24'hF0F0F0, 24'hFF00FF, 24'hF000F0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'b0001, 24'hF0F0F0, 24'h0F0000, 24'hFFF0F0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'b0101, 24'hFFFFFF, 24'h00FF00, 24'hFF00FF, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'b0100, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{4'b1010, 24'h800000, 24'h000001, 24'h7FFFFF, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{4'b0011, 24'h000001, 24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{4'b1111, 24'h123456, 24'h654321, 24'h000000, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{4'b0110, 24'h000003, 24'd4,      24'h000030, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{4'b1010, 24'h000005, 24'h000007, 24'hFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{4'b0010, 24'h800000, 24'h800000, 24'h000000, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{4'b0011, 24'h800000, 24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 1'b0};

        bus.start = 1'b0; bus.alu_ctrl = '0; bus.a = '0; bus.b = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",     {31'd0, bus.busy},     32'd0);
        chk("rst_done",     {31'd0, bus.done},     32'd0);
        chk("rst_result",   {8'd0, bus.result},    32'd0);
        chk("rst_zero",     {31'd0, bus.zero},     32'd1);
        chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        chk("rst_illegal",  {31'd0, bus.illegal},  32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_done", {31'd0, bus.done}, 32'd0);

        // Back-to-back issue: one Done per cycle
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].ctrl, vecs[i].a, vecs[i].b, 1'b1,
                  vecs[i].res, vecs[i].z, vecs[i].ov, vecs[i].il);
            chk("b2b_done", {31'd0, bus.done}, 32'd1);
        end
        repeat (2) @(posedge clk); #1;
        chk("table_drain", sbq.size(), 32'd0);

        // Multiply with an ignored mid-flight Start
        issue(4'b0111, 24'h001000, 24'h000300, 1'b1, 24'h300000, 1'b0, 1'b0, 1'b0);
        chk("mul_busy_accept", {31'd0, bus.busy}, 32'd1);
        for (int k = 1; k <= 23; k++) begin
            @(posedge clk); #1;
            chk("mul_busy", {31'd0, bus.busy}, 32'd1);
            chk("mul_no_done", {31'd0, bus.done}, 32'd0);
            if (k == 5) begin
                bus.start = 1'b1; bus.alu_ctrl = 4'b0010;
                bus.a = 24'h000001; bus.b = 24'h000001;
            end
            if (k == 6) bus.start = 1'b0;
            if (k == 10) chk("mul_result_held", {8'd0, bus.result}, 32'd1);
        end
        @(posedge clk); #1;
        chk("mul_done", {31'd0, bus.done}, 32'd1);
        chk("mul_busy_drop", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        chk("mul_done_pulse", {31'd0, bus.done}, 32'd0);

        // Truncated multiply, then ADD issued in the Done cycle
        issue(4'b0111, 24'hFFFFFF, 24'h000002, 1'b1, 24'hFFFFFE, 1'b0, 1'b0, 1'b0);
        repeat (24) @(posedge clk);
        #1;
        chk("mul2_done", {31'd0, bus.done}, 32'd1);
        issue(4'b0010, 24'h000010, 24'h000020, 1'b1, 24'h000030, 1'b0, 1'b0, 1'b0);
        chk("add_after_mul_done", {31'd0, bus.done}, 32'd1);
        chk("add_after_mul_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        chk("add_done_pulse", {31'd0, bus.done}, 32'd0);

        // Reset aborts a multiply in flight
        issue(4'b0111, 24'h000005, 24'h000005, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        chk("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",   {31'd0, bus.busy},  32'd0);
        chk("abort_result", {8'd0, bus.result}, 32'd0);
        chk("abort_done",   {31'd0, bus.done},  32'd0);
        chk("abort_zero",   {31'd0, bus.zero},  32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_idle_busy",   {31'd0, bus.busy},  32'd0);
        chk("abort_idle_result", {8'd0, bus.result}, 32'd0);

        // Unsupported code
        issue(4'b1111, 24'h00ABCD, 24'h000001, 1'b1, 24'h000000, 1'b1, 1'b0, 1'b1);
        chk("illegal_flag", {31'd0, bus.illegal}, 32'd1);
        chk("illegal_done", {31'd0, bus.done},    32'd1);
        @(posedge clk); #1;
        chk("illegal_clear", {31'd0, bus.illegal}, 32'd0);
        chk("illegal_done_clear", {31'd0, bus.done}, 32'd0);

        repeat (2) @(posedge clk); #1;
        chk("final_drain", sbq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
# alu_exec_unit

Sequential 24-bit execute stage directly downstream of the ALU control decoder: it consumes the 4-bit ALU control code plus two register operands and produces a registered result, zero flag and overflow flag for writeback and branch resolution. Logic ops, add/sub, compare and shift complete in one cycle. Multiply is an iterative shift-add sequence of 24 cycles behind a start/done handshake, so the pipeline stalls on Busy.

## Interface
- WIDTH, 24, operand/result width; all rules below assume 24.
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled on the rising edge, accepted only when Busy=0.
- ALUCtrl  in  4  operation code, captured on accept.
- A  in  WIDTH  operand A, captured on accept.
- B  in  WIDTH  operand B, captured on accept.
- Busy  out  1  high while a multiply is in progress.
- Done  out  1  one-cycle pulse when Result is valid.
- Result  out  WIDTH  registered result, held until the next Done.
- Zero  out  1  (Result==0), updated together with Result.
- Overflow  out  1  signed overflow for add/sub codes, else 0; updated with Result.
- Illegal  out  1  high for one cycle with Done when the captured code is unsupported.

## Operation
- Codes:
  - 0000 AND, 0001 OR, 0101 XOR.
  - 0010 ADD, 0100 ADD (load/store address), 1010 SUB, 1100 SUB (branch compare).
  - 0011 SLT: signed; Result=1 if A<B, else 0.
  - 0110 SLL: A << B[4:0]; shift amount ≥24 gives 0.
  - 0111 MUL: lower 24 bits of the unsigned product A*B.
- Any other code: Result=0, Zero=1, Overflow=0, Illegal=1, latency 1.
- Add/sub are WIDTH-bit modulo. Overflow = signed overflow: sign(A)==sign(B')!=sign(Result), where B'=B for add and ~B+1 for sub.
- States: IDLE, MUL.
  - IDLE + accepted non-MUL code: compute, register outputs, pulse Done at the next edge, stay IDLE.
  - IDLE + accepted MUL: load multiplicand/multiplier/accumulator, clear counter to 0, go to MUL, Busy=1.
  - MUL, each cycle: if multiplier bit0 is set, add the shifted multiplicand to the accumulator; shift; counter+1.
  - MUL, counter==23 (24th iteration): register Result, pulse Done, drop Busy, return to IDLE.
- Start while Busy=1 is ignored; no queuing.
- Operands are captured on accept; later changes on A/B/ALUCtrl have no effect.
- Reset_n low at any time: state IDLE, counter 0, any multiply in progress aborted with no Done.
- Reset values: Busy=0, Done=0, Result=0, Zero=1, Overflow=0, Illegal=0.

## Timing
- Non-MUL: accept on edge N, Done=1 and Result valid after edge N+1 (latency 1). Back-to-back Start every cycle sustains one result per cycle.
- MUL: accept on edge N. Busy=1 after edges N+1 through N+23. Done=1 and Busy=0 after edge N+24.
- In the Done cycle Busy=0, so a Start in that cycle is accepted and issue stays back-to-back.
- Done is never high for two consecutive cycles unless two ops were accepted on consecutive edges.
- Result, Zero and Overflow change only on a Done edge or on reset.
- Illegal asserts only together with Done.

## Test plan
- Reset release, then ADD A=0x7FFFFF B=0x000001 -> 1 cycle later Done=1, Result=0x800000, Overflow=1, Zero=0.
- SUB (1100) A=0x000123 B=0x000123 -> Result=0, Zero=1, Overflow=0. Then SLT A=0xFFFFFF B=0x000001 -> Result=1.
- SLL A=0x000001 B=23 -> 0x800000. SLL with B=24 -> 0, Zero=1.
- MUL A=0x001000 B=0x000300 -> Busy high 23 cycles, Done on the 24th cycle, Result=0x300000. A Start issued mid-multiply is ignored and Result is unchanged.
- MUL A=0xFFFFFF B=0x000002 -> Result=0xFFFFFE (truncated). Start ADD in the Done cycle -> accepted, Done on the following cycle.
- Reset_n pulsed low at the 10th MUL cycle -> Busy=0 and Result=0 immediately, no Done. Unsupported code 1111 -> Illegal=1 and Done=1 for one cycle, Result=0.
